// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation search pipeline.
// Holds the window-shift mode encoding used by every shift stage.
`default_nettype none

package me_pkg;

  typedef enum logic [1:0] {
    ME_MODE_PASS = 2'b00,
    ME_MODE_SHL  = 2'b01,
    ME_MODE_SHR  = 2'b10,
    ME_MODE_LOAD = 2'b11
  } me_mode_e;

endpackage

`default_nettype wire

// File: rtl/me_side_delay.sv
// Enable-gated shift-register delay line with asynchronous clear.
// Output is the last of DEPTH stages; all stages advance together on en.
`default_nettype none

module me_side_delay #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            stage_q[gi] <= '0;
          end else if (en) begin
            stage_q[gi] <= din;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            stage_q[gi] <= '0;
          end else if (en) begin
            stage_q[gi] <= stage_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign dout = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/me_win_shift_stage.sv
// Reference-window shift stage: inserts a side pixel at one end of the row,
// tracks column position with wrap, and forwards remaining side pixels delayed.
`default_nettype none

module me_win_shift_stage
  import me_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int WIN_PIX  = 16,
  parameter int SIDE_PIX = 3,
  parameter int SIDE_DLY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [1:0]                    mode_i,
  input  logic [WIN_PIX*PIX_W-1:0]      win_i,
  input  logic [SIDE_PIX*PIX_W-1:0]     side_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [WIN_PIX*PIX_W-1:0]      win_o,
  output logic [(SIDE_PIX-1)*PIX_W-1:0] side_o,
  output logic [$clog2(WIN_PIX)-1:0]    col_o,
  output logic                          wrap_o
);

  localparam int COL_W = $clog2(WIN_PIX);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIN_PIX - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  me_mode_e                   mode;
  logic                       accept;
  logic                       out_valid_q;
  logic [WIN_PIX*PIX_W-1:0]   win_q;
  logic [WIN_PIX*PIX_W-1:0]   win_nxt;
  logic [COL_W-1:0]           col_q;
  logic [COL_W-1:0]           col_nxt;
  logic                       wrap_q;
  logic                       wrap_nxt;

  assign mode       = me_mode_e'(mode_i);
  // Ready depends only on the output register and downstream, never on in_valid_i.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    win_nxt  = win_i;
    col_nxt  = col_q;
    wrap_nxt = 1'b0;
    case (mode)
      ME_MODE_SHL: begin
        win_nxt = {side_i[PIX_W-1:0], win_i[WIN_PIX*PIX_W-1:PIX_W]};
        if (col_q == COL_MAX) begin
          col_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          col_nxt = col_q + COL_ONE;
        end
      end
      ME_MODE_SHR: begin
        win_nxt = {win_i[(WIN_PIX-1)*PIX_W-1:0], side_i[PIX_W-1:0]};
        if (col_q == '0) begin
          col_nxt  = COL_MAX;
          wrap_nxt = 1'b1;
        end else begin
          col_nxt = col_q - COL_ONE;
        end
      end
      ME_MODE_LOAD: begin
        col_nxt = '0;
      end
      default: begin
        col_nxt = col_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      win_q       <= '0;
      col_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        win_q       <= win_nxt;
        col_q       <= col_nxt;
        wrap_q      <= wrap_nxt;
      end else if (out_ready_i) begin
        // Consumed with nothing new: drop valid, keep data registers as they are.
        out_valid_q <= 1'b0;
      end
    end
  end

  me_side_delay #(
    .WIDTH ((SIDE_PIX-1)*PIX_W),
    .DEPTH (SIDE_DLY)
  ) u_side_delay (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en      (accept),
    .din     (side_i[SIDE_PIX*PIX_W-1:PIX_W]),
    .dout    (side_o)
  );

  assign out_valid_o = out_valid_q;
  assign win_o       = win_q;
  assign col_o       = col_q;
  assign wrap_o      = wrap_q;

endmodule

`default_nettype wire

// File: doc/me_win_shift_stage.md
# me_win_shift_stage

Parametrised reference-window shift stage for the motion-estimation search pipeline. Each accepted beat takes a WIN_PIX-pixel row window and a bundle of SIDE_PIX incoming side pixels. It inserts side pixel 0 at one end of the window, in a direction chosen by mode. The remaining side pixels go through a configurable delay line, and a column-position counter tracks the shift. Stages chain back-to-back with valid/ready backpressure between them.

## Interface
- PIX_W, 8, bits per pixel
- WIN_PIX, 16, pixels per window row (≥2)
- SIDE_PIX, 3, side pixels per beat (≥2)
- SIDE_DLY, 1, register stages on forwarded side pixels (≥1)
- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  stage can accept
- mode_i  input  2  00 PASS, 01 SHIFT_L, 10 SHIFT_R, 11 LOAD
- win_i  input  WIN_PIX*PIX_W  window row; pixel k at [k*PIX_W +: PIX_W]
- side_i  input  SIDE_PIX*PIX_W  side pixels; pixel 0 is the insert pixel
- out_valid_o  output  1  output beat valid
- out_ready_i  input  1  downstream accepts
- win_o  output  WIN_PIX*PIX_W  registered shifted window
- side_o  output  (SIDE_PIX-1)*PIX_W  delayed side pixels 1..SIDE_PIX-1
- col_o  output  $clog2(WIN_PIX)  column position after this beat
- wrap_o  output  1  col wrapped on this beat

## Operation
- Accept = in_valid_i && in_ready_o. Output register, side delay line and counter update only on accept.
- Window update on accept:
  - PASS: win_o ← win_i; col unchanged.
  - SHIFT_L: win_o ← {side_i[PIX_W-1:0], win_i[WIN_PIX*PIX_W-1:PIX_W]}; col ← col+1.
  - SHIFT_R: win_o ← {win_i[(WIN_PIX-1)*PIX_W-1:0], side_i[PIX_W-1:0]}; col ← col−1.
  - LOAD: win_o ← win_i; col ← 0.
- Counter wrap:
  - col+1 from WIN_PIX−1 gives 0 with wrap_o=1.
  - col−1 from 0 gives WIN_PIX−1 with wrap_o=1.
  - wrap_o=0 on all other beats, including LOAD and PASS.
  - wrap_o is registered with the beat and held while stalled.
- Side delay line:
  - SIDE_DLY stages, each (SIDE_PIX-1)*PIX_W wide, loaded from side_i[SIDE_PIX*PIX_W-1:PIX_W].
  - Shifts one stage per accept, independent of mode; side_o = last stage.
  - SIDE_DLY=1: side_o belongs to the same beat as win_o.
  - SIDE_DLY=n: side_o belongs to the beat accepted n−1 beats earlier.
- Reset: every register and output is 0, including out_valid_o, win_o, side_o (all stages), col_o and wrap_o. in_ready_o=1.
- Reset mid-stream: the held beat is discarded and the delay line is cleared.

## Timing
- Latency: one cycle from accept to out_valid_o/win_o/col_o.
- in_ready_o = !out_valid_o || out_ready_i. This is combinational, with no path from in_valid_i.
- Stall (out_valid_o && !out_ready_i):
  - in_ready_o=0.
  - All outputs are held stable and no state changes.
- Consume and accept in the same cycle: the new beat replaces the old one and out_valid_o stays 1. Full throughput is one beat per cycle.
- Consume without accept: out_valid_o=0 next cycle; data registers hold their values.
- mode_i and all data are sampled only on accept; their values are don't-care otherwise.

## Structure
- Shared package me_pkg holds the mode encodings ME_MODE_PASS/SHL/SHR/LOAD as a 2-bit typedef.
- Sub-module me_side_delay: an enable-gated shift-register delay line with WIDTH and DEPTH parameters and async reset to 0. Instantiated once for the side path.
- Window mux, counter and handshake logic stay in the top module.

## Test plan
- Reset, defaults. Assert rst_n_i=0 → out_valid_o=0, win_o=0, side_o=0, col_o=0, wrap_o=0, in_ready_o=1.
- SHIFT_L, defaults. Drive win_i byte k = k, side_i=0xCCBBAA, out_ready_i=1 → next cycle win_o=0xAA0F0E…0201, side_o=0xCCBB, col_o=1, wrap_o=0.
- Wrap. One LOAD, then 16 SHIFT_L beats → col_o steps 1..15, then 0 with wrap_o=1 on beat 16 only.
- SHIFT_R from col 0. win_i byte k = k, side_i=0x0000AA → win_o=0x0E0D…00AA, col_o=15, wrap_o=1.
- Backpressure:
  - out_ready_i=0 for 3 cycles with in_valid_i=1 → exactly one beat accepted, in_ready_o=0, outputs stable.
  - Raise out_ready_i → next beat accepted in the consume cycle, out_valid_o stays 1.
- SIDE_DLY=3 build:
  - With win_o showing beat N, side_o shows beat N−2's side pixels; side_o stays 0 until beat 3.
  - Pulse reset mid-stream → all outputs 0, delay line cleared.
